fetch_ctrl_b32: RTL and testbench
=================================

Name: fetch_ctrl_b32

Overview:
- Instruction-fetch sequencer that drives the write side of the 32-bit PC register (PC_register_b32).
- Reads the registered PC, issues a request/acknowledge read to instruction memory, and presents the fetched word downstream with a valid/ready handshake.
- Computes the next PC, either sequential or a branch/jump redirect, and writes it back with a one-cycle write-enable pulse.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded into the PC register after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_cur  input  32  current PC, driven by PCout of the PC register.
- pc_wEn  output  1  write enable to the PC register (wEn); one-cycle pulses.
- pc_next  output  32  next PC value to the PC register (PCin).
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  instruction memory read address.
- imem_ack  input  1  one-cycle read acknowledge; imem_data is valid in the same cycle.
- imem_data  input  32  instruction word.
- instr  output  32  fetched instruction.
- instr_valid  output  1  instr holds a valid instruction.
- instr_ready  input  1  downstream accepts instr.
- redirect  input  1  branch/jump taken, one cycle.
- redirect_target  input  32  target PC for redirect.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-request):
  - Outputs: pc_wEn=0, pc_next=RESET_PC, imem_req=0, imem_addr=0, instr=0, instr_valid=0.
  - Internal: pend=0, pend_tgt=0, state=S_INIT.
- All outputs are registered. The PC register samples pc_wEn/pc_next at the edge that ends the cycle in which they are high, so pc_cur shows the new value one cycle later.
- S_INIT: for one cycle, drive pc_wEn=1, pc_next=RESET_PC, then go to S_UPD.
- S_UPD: the cycle in which pc_wEn is high.
  - Next cycle: pc_wEn=0, imem_addr<=pc_cur (updated value), imem_req=1, go to S_REQ.
- S_REQ: imem_req and imem_addr are held stable until the cycle in which imem_ack=1.
  - On ack with pend=0: instr<=imem_data, instr_valid<=1, imem_req<=0, go to S_HOLD.
  - On ack with pend=1: discard imem_data; pc_wEn<=1, pc_next<=pend_tgt, pend<=0, imem_req<=0, go to S_UPD.
- S_HOLD: instr_valid=1 and instr is stable until instr_valid && instr_ready.
  - On handshake: instr_valid<=0, pc_wEn<=1, pc_next<=pc_cur+PC_STEP, go to S_UPD.
- Latencies:
  - Ack in cycle N gives instr_valid in N+1.
  - Handshake in cycle N gives pc_wEn in N+1 and imem_req with the new address in N+2.
- Redirect rules (redirect is ignored in S_INIT):
  - In S_REQ: pend<=1, pend_tgt<=redirect_target. A later redirect before the ack overwrites pend_tgt (newest wins).
  - In S_REQ with imem_ack in the same cycle: data is dropped; pc_wEn<=1, pc_next<=redirect_target, go to S_UPD.
  - In S_HOLD: instr_valid<=0, pc_wEn<=1, pc_next<=redirect_target, go to S_UPD. Redirect wins over a same-cycle valid&ready; the instruction counts as consumed and no sequential increment occurs.
  - In S_UPD: pc_wEn<=1, pc_next<=redirect_target, stay in S_UPD for one more cycle (the second write overrides the first).
- Arithmetic: 32-bit addition, modulo 2^32; 32'hFFFF_FFFC+4 = 0 with no flag.
- imem_ack outside S_REQ is ignored.
- imem_data is sampled only on an ack in S_REQ.
- At most one outstanding memory request at any time.
- Never more than one instr_valid word.

Test Plan:
- Reset, then release with RESET_PC=0 -> pc_wEn pulses one cycle with pc_next=0; next cycle imem_req=1, imem_addr=0.
- Ack with imem_data=32'h1234_5678 after 3 wait cycles, instr_ready=1 -> instr=32'h1234_5678 with instr_valid high one cycle; pc_next=4; next imem_addr=4.
- instr_ready held 0 for 5 cycles -> instr_valid and instr stable, no pc_wEn; release -> pc_next=pc_cur+4.
- Redirect to 32'h100 while S_REQ is pending, then ack with 32'hDEAD_BEEF -> instr_valid stays 0, pc_next=32'h100, next imem_addr=32'h100.
- Redirect to 32'h200 in the same cycle as valid&ready at PC 8 -> pc_next=32'h200, not 12.
- PC at 32'hFFFF_FFFC, handshake -> pc_next=0.
- Assert reset in the middle of S_REQ -> imem_req and instr_valid drop immediately; the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_b32_if.sv
// fetch_ctrl_b32_if: PC-register write port, instruction-memory read port and downstream instruction handshake.
interface fetch_ctrl_b32_if;
  logic [31:0] pc_cur, pc_next, imem_addr, imem_data, instr, redirect_target;
  logic pc_wEn, imem_req, imem_ack, instr_valid, instr_ready, redirect;
  modport master(
    input pc_cur, imem_ack, imem_data, instr_ready, redirect, redirect_target,
    output pc_wEn, pc_next, imem_req, imem_addr, instr, instr_valid
  );
  modport slave(
    output pc_cur, imem_ack, imem_data, instr_ready, redirect, redirect_target,
    input pc_wEn, pc_next, imem_req, imem_addr, instr, instr_valid
  );
endinterface

// File: rtl/fetch_ctrl_b32.sv
// fetch_ctrl_b32: instruction-fetch sequencer driving PC writes, memory requests and the instruction handshake.
module fetch_ctrl_b32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input logic clock,
  input logic reset,
  fetch_ctrl_b32_if.master f
);
  typedef enum logic [1:0] {S_INIT, S_UPD, S_REQ, S_HOLD} state_t;
  state_t state, state_n;
  logic wen, wen_n, req, req_n, valid, valid_n, pend, pend_n;
  logic [31:0] pcn, pcn_n, addr, addr_n, instr, instr_n, pend_tgt, pend_tgt_n;
  assign f.pc_wEn = wen;
  assign f.pc_next = pcn;
  assign f.imem_req = req;
  assign f.imem_addr = addr;
  assign f.instr = instr;
  assign f.instr_valid = valid;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_INIT;
      wen <= 1'b0;
      pcn <= RESET_PC;
      req <= 1'b0;
      addr <= '0;
      instr <= '0;
      valid <= 1'b0;
      pend <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state <= state_n;
      wen <= wen_n;
      pcn <= pcn_n;
      req <= req_n;
      addr <= addr_n;
      instr <= instr_n;
      valid <= valid_n;
      pend <= pend_n;
      pend_tgt <= pend_tgt_n;
    end
  // pcn holds the value being written, which is what pc_cur will show once the write lands
  always_comb begin
    state_n = state;
    wen_n = 1'b0;
    pcn_n = pcn;
    req_n = req;
    addr_n = addr;
    instr_n = instr;
    valid_n = valid;
    pend_n = pend;
    pend_tgt_n = pend_tgt;
    case (state)
      S_INIT: begin
        wen_n = 1'b1;
        pcn_n = RESET_PC;
        state_n = S_UPD;
      end
      S_UPD:
        if (f.redirect) begin
          wen_n = 1'b1;
          pcn_n = f.redirect_target;
        end else begin
          addr_n = pcn;
          req_n = 1'b1;
          state_n = S_REQ;
        end
      S_REQ:
        if (f.imem_ack) begin
          req_n = 1'b0;
          pend_n = 1'b0;
          if (f.redirect || pend) begin
            wen_n = 1'b1;
            pcn_n = f.redirect ? f.redirect_target : pend_tgt;
            state_n = S_UPD;
          end else begin
            instr_n = f.imem_data;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end else if (f.redirect) begin
          pend_n = 1'b1;
          pend_tgt_n = f.redirect_target;
        end
      default:
        if (f.redirect || f.instr_ready) begin
          valid_n = 1'b0;
          wen_n = 1'b1;
          pcn_n = f.redirect ? f.redirect_target : f.pc_cur + PC_STEP;
          state_n = S_UPD;
        end
    endcase
  end
endmodule

// File: tb/tb_fetch_ctrl_b32.sv
// tb_fetch_ctrl_b32: scoreboarded bench for fetch_ctrl_b32 with a behavioural PC register.
module tb_fetch_ctrl_b32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pc_reg = 32'hDEAD_0000;
  logic [31:0] pc_q[$], instr_q[$];
  logic [31:0] last_wr = '0, mon_exp;
  logic req_prev = 1'b0, val_prev = 1'b0;
  int nvec = 0, nfail = 0;

  fetch_ctrl_b32_if bus();
  fetch_ctrl_b32 #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (.clock(clock), .reset(reset), .f(bus));

  always #5 clock = ~clock;
  assign bus.pc_cur = pc_reg;
  always @(posedge clock) if (bus.pc_wEn) pc_reg <= bus.pc_next;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.pc_wEn) begin
        nvec++;
        if (pc_q.size() == 0) begin
          nfail++;
          $display("FAIL pc_write: got pc_next=%h, no write expected", bus.pc_next);
        end else begin
          mon_exp = pc_q.pop_front();
          last_wr = mon_exp;
          if (bus.pc_next !== mon_exp) begin
            nfail++;
            $display("FAIL pc_write: got pc_next=%h, expected %h", bus.pc_next, mon_exp);
          end
        end
      end
      if (bus.imem_req && !req_prev) begin
        nvec++;
        if (bus.imem_addr !== last_wr) begin
          nfail++;
          $display("FAIL fetch_addr: got imem_addr=%h, expected %h", bus.imem_addr, last_wr);
        end
      end
      if (bus.instr_valid && !val_prev) begin
        nvec++;
        if (instr_q.size() == 0) begin
          nfail++;
          $display("FAIL instr_out: got instr=%h, no instruction expected", bus.instr);
        end else begin
          mon_exp = instr_q.pop_front();
          if (bus.instr !== mon_exp) begin
            nfail++;
            $display("FAIL instr_out: got instr=%h, expected %h", bus.instr, mon_exp);
          end
        end
      end
    end
    req_prev = bus.imem_req;
    val_prev = bus.instr_valid;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      ok = which == 0 ? bus.pc_wEn : which == 1 ? bus.imem_req : bus.instr_valid;
      if (!ok) step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    nvec += 6;
    if (bus.pc_wEn !== 1'b0) begin nfail++; $display("FAIL rst_wen: got %b, expected 0", bus.pc_wEn); end
    if (bus.pc_next !== 32'h0) begin nfail++; $display("FAIL rst_pc_next: got %h, expected 0", bus.pc_next); end
    if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL rst_req: got %b, expected 0", bus.imem_req); end
    if (bus.imem_addr !== 32'h0) begin nfail++; $display("FAIL rst_addr: got %h, expected 0", bus.imem_addr); end
    if (bus.instr !== 32'h0) begin nfail++; $display("FAIL rst_instr: got %h, expected 0", bus.instr); end
    if (bus.instr_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b, expected 0", bus.instr_valid); end
  endtask

  task automatic test_init();
    bit ok;
    pc_q.push_back(32'h0);
    reset = 1'b0;
    wait_for(0, ok);
    nvec++;
    if (ok !== 1'b1) begin nfail++; $display("FAIL init_wen: got no pc_wEn, expected a pulse"); end
    step();
    nvec += 2;
    if (bus.pc_wEn !== 1'b0) begin nfail++; $display("FAIL init_pulse: got pc_wEn=%b, expected 0", bus.pc_wEn); end
    if (bus.imem_req !== 1'b1) begin nfail++; $display("FAIL init_req: got imem_req=%b, expected 1", bus.imem_req); end
  endtask

  task automatic test_basic();
    bit ok;
    instr_q.push_back(32'h1234_5678);
    pc_q.push_back(32'h4);
    bus.instr_ready = 1'b1;
    wait_for(1, ok);
    nvec++;
    if (ok !== 1'b1) begin nfail++; $display("FAIL basic_req: got no imem_req, expected 1"); end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
        nfail++;
        $display("FAIL basic_hold_req: got req=%b addr=%h, expected 1/0", bus.imem_req, bus.imem_addr);
      end
    end
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h1234_5678;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    nvec += 2;
    if (bus.instr_valid !== 1'b1) begin nfail++; $display("FAIL basic_valid: got %b, expected 1", bus.instr_valid); end
    if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL basic_req_drop: got %b, expected 0", bus.imem_req); end
    step();
    nvec += 2;
    if (bus.instr_valid !== 1'b0) begin nfail++; $display("FAIL basic_valid_pulse: got %b, expected 0", bus.instr_valid); end
    if (bus.pc_wEn !== 1'b1) begin nfail++; $display("FAIL basic_wen: got %b, expected 1", bus.pc_wEn); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    instr_q.push_back(32'hA5A5_0004);
    wait_for(1, ok);
    nvec++;
    if (ok !== 1'b1) begin nfail++; $display("FAIL stall_req: got no imem_req, expected 1"); end
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'hA5A5_0004;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hA5A5_0004 || bus.pc_wEn !== 1'b0) begin
        nfail++;
        $display("FAIL stall_hold: got valid=%b instr=%h wen=%b, expected 1/a5a50004/0", bus.instr_valid, bus.instr, bus.pc_wEn);
      end
    end
    pc_q.push_back(32'h8);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    nvec++;
    if (bus.instr_valid !== 1'b0 || bus.pc_wEn !== 1'b1) begin
      nfail++;
      $display("FAIL stall_release: got valid=%b wen=%b, expected 0/1", bus.instr_valid, bus.pc_wEn);
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    instr_q.push_back(32'h0000_0013);
    wait_for(1, ok);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h0000_0013;
    step();
    bus.imem_ack = 1'b0;
    pc_q.push_back(32'h200);
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    nvec++;
    if (ok !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc_wEn !== 1'b1) begin
      nfail++;
      $display("FAIL redir_hold: got req_seen=%b valid=%b wen=%b, expected 1/0/1", ok, bus.instr_valid, bus.pc_wEn);
    end
  endtask

  task automatic test_redirect_pend();
    bit ok;
    wait_for(1, ok);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h300;
    step();
    bus.redirect_target = 32'h100;
    step();
    bus.redirect = 1'b0;
    pc_q.push_back(32'h100);
    nvec++;
    if (ok !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      nfail++;
      $display("FAIL pend_req_stable: got req=%b addr=%h, expected 1/00000200", bus.imem_req, bus.imem_addr);
    end
    step();
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    nvec++;
    if (bus.instr_valid !== 1'b0 || bus.pc_wEn !== 1'b1) begin
      nfail++;
      $display("FAIL pend_drop: got valid=%b wen=%b, expected 0/1", bus.instr_valid, bus.pc_wEn);
    end
  endtask

  task automatic test_redirect_ack_upd();
    bit ok;
    wait_for(1, ok);
    pc_q.push_back(32'h400);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h0BAD_0BAD;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h400;
    step();
    bus.imem_ack = 1'b0;
    nvec++;
    if (ok !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc_wEn !== 1'b1) begin
      nfail++;
      $display("FAIL redir_ack: got valid=%b wen=%b, expected 0/1", bus.instr_valid, bus.pc_wEn);
    end
    pc_q.push_back(32'h500);
    bus.redirect_target = 32'h500;
    step();
    bus.redirect = 1'b0;
    nvec++;
    if (bus.pc_wEn !== 1'b1 || bus.imem_req !== 1'b0) begin
      nfail++;
      $display("FAIL redir_upd: got wen=%b req=%b, expected 1/0", bus.pc_wEn, bus.imem_req);
    end
    step();
    nvec++;
    if (bus.pc_wEn !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h500) begin
      nfail++;
      $display("FAIL redir_upd_fetch: got wen=%b req=%b addr=%h, expected 0/1/00000500", bus.pc_wEn, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    pc_q.push_back(32'hFFFF_FFFC);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    instr_q.push_back(32'h0000_0001);
    pc_q.push_back(32'h0);
    bus.instr_ready = 1'b1;
    wait_for(1, ok);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'h0000_0001;
    step();
    bus.imem_ack = 1'b0;
    step();
    bus.instr_ready = 1'b0;
    nvec++;
    if (ok !== 1'b1 || bus.pc_wEn !== 1'b1 || bus.pc_next !== 32'h0) begin
      nfail++;
      $display("FAIL wrap: got wen=%b pc_next=%h, expected 1/00000000", bus.pc_wEn, bus.pc_next);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_for(1, ok);
    step();
    reset = 1'b1;
    #1;
    nvec++;
    if (ok !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc_wEn !== 1'b0) begin
      nfail++;
      $display("FAIL mid_reset: got req=%b valid=%b wen=%b, expected 0/0/0", bus.imem_req, bus.instr_valid, bus.pc_wEn);
    end
    step();
    step();
    pc_q.push_back(32'h0);
    reset = 1'b0;
    wait_for(0, ok);
    nvec++;
    if (ok !== 1'b1) begin nfail++; $display("FAIL mid_reset_restart: got no pc_wEn, expected a pulse"); end
    instr_q.push_back(32'hCAFE_F00D);
    pc_q.push_back(32'h4);
    bus.instr_ready = 1'b1;
    wait_for(1, ok);
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'hCAFE_F00D;
    step();
    bus.imem_ack = 1'b0;
    repeat (4) step();
    bus.instr_ready = 1'b0;
    repeat (4) step();
    nvec += 2;
    if (pc_q.size() !== 0) begin nfail++; $display("FAIL pc_writes_left: got %0d pending, expected 0", pc_q.size()); end
    if (instr_q.size() !== 0) begin nfail++; $display("FAIL instrs_left: got %0d pending, expected 0", instr_q.size()); end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    test_reset();
    test_init();
    test_basic();
    test_stall();
    test_redirect_hold();
    test_redirect_pend();
    test_redirect_ack_upd();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
